// File: rtl/id_scoreboard_rf_pkg.sv
// Shared constants and the ID/EX record for the decode-stage register file.
package id_scoreboard_rf_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_CNT_DEF = 8;
    localparam int ADDR_W_DEF  = 3;
    localparam int PEND_W_DEF  = 2;

    // Largest number of in-flight writes one register may carry.
    localparam int PEND_MAX = (1 << PEND_W_DEF) - 1;

    // Operands latched into execute. Field widths track the default
    // DATA_W / ADDR_W, so instances keep those two at their defaults.
    typedef struct packed {
        logic                  valid;
        logic [DATA_W_DEF-1:0] rs_data;
        logic [DATA_W_DEF-1:0] rt_data;
        logic [ADDR_W_DEF-1:0] rd_sel;
        logic                  rd_wr;
    } idex_t;

endpackage

// File: rtl/id_scoreboard_rf_if.sv
// Decode, writeback and execute-side signals of the decode register file.
interface id_scoreboard_rf_if
    import id_scoreboard_rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              id_valid;
    logic [ADDR_W-1:0] rs_sel;
    logic              rs_used;
    logic [ADDR_W-1:0] rt_sel;
    logic              rt_used;
    logic [ADDR_W-1:0] rd_sel;
    logic              rd_wr;
    logic              ex_stall;
    logic              flush;
    logic              wb_write;
    logic [ADDR_W-1:0] wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              hazard_stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [ADDR_W-1:0] ex_rd_sel;
    logic              ex_rd_wr;
    logic              err;

    // Decode/writeback control side.
    modport master (
        output id_valid, rs_sel, rs_used, rt_sel, rt_used, rd_sel, rd_wr,
               ex_stall, flush, wb_write, wb_sel, wb_data,
        input  hazard_stall, ex_valid, ex_rs_data, ex_rt_data, ex_rd_sel,
               ex_rd_wr, err
    );

    // Register file side.
    modport slave (
        input  id_valid, rs_sel, rs_used, rt_sel, rt_used, rd_sel, rd_wr,
               ex_stall, flush, wb_write, wb_sel, wb_data,
        output hazard_stall, ex_valid, ex_rs_data, ex_rt_data, ex_rd_sel,
               ex_rd_wr, err
    );

endinterface

// File: rtl/id_scoreboard_rf_sb.sv
// Pending-write scoreboard: one saturating counter per register, RAW and
// overflow stall detection, and the issue qualifier.
module id_scoreboard
    import id_scoreboard_rf_pkg::*;
#(
    parameter int REG_CNT = REG_CNT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PEND_W  = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] rs_sel,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] rt_sel,
    input  logic              rt_used,
    input  logic [ADDR_W-1:0] rd_sel,
    input  logic              rd_wr,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              wb_write,
    input  logic [ADDR_W-1:0] wb_sel,
    output logic              hazard_stall,
    output logic              issue
);

    logic [PEND_W-1:0] pend [REG_CNT];
    logic [PEND_W-1:0] rs_pend, rt_pend, rd_pend;
    logic              rs_ready, rt_ready, rd_full;
    logic [REG_CNT-1:0] inc, dec;

    // Look up the counters addressed by decode; out-of-range selects read 0
    // so they never stall (the top flags them as errors instead).
    always_comb begin
        rs_pend = '0;
        rt_pend = '0;
        rd_pend = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            if (int'(rs_sel) == i) rs_pend = pend[i];
            if (int'(rt_sel) == i) rt_pend = pend[i];
            if (int'(rd_sel) == i) rd_pend = pend[i];
        end
    end

    // A single outstanding write that lands this cycle is covered by bypass.
    assign rs_ready = (rs_pend == '0) ||
                      (rs_pend == PEND_W'(1) && wb_write && wb_sel == rs_sel);
    assign rt_ready = (rt_pend == '0) ||
                      (rt_pend == PEND_W'(1) && wb_write && wb_sel == rt_sel);
    assign rd_full  = (rd_pend == '1);

    assign hazard_stall = id_valid && !flush &&
                          ((rs_used && !rs_ready) || (rt_used && !rt_ready) ||
                           (rd_wr && rd_full));
    assign issue = id_valid && !hazard_stall && !ex_stall && !flush;

    // Per-register increment on issue, decrement on writeback of a pending reg.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            inc[i] = issue && rd_wr && int'(rd_sel) == i;
            dec[i] = wb_write && int'(wb_sel) == i && pend[i] != '0;
        end
    end

    // Counter update; flush discards all in-flight bookkeeping, and late
    // writebacks of squashed instructions then hit a zero counter and are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) pend[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < REG_CNT; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                if (inc[i] && !dec[i])      pend[i] <= pend[i] + PEND_W'(1);
                else if (dec[i] && !inc[i]) pend[i] <= pend[i] - PEND_W'(1);
            end
        end
    end

endmodule

// File: rtl/id_scoreboard_rf.sv
// Decode-stage register file with writeback bypass, pending-write
// scoreboard and a registered ID/EX operand stage.
module id_scoreboard_rf
    import id_scoreboard_rf_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_CNT = REG_CNT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PEND_W  = PEND_W_DEF
) (
    input logic               clk,
    input logic               rst,
    id_scoreboard_rf_if.slave bus
);

    logic [DATA_W-1:0] regs [REG_CNT];
    logic [DATA_W-1:0] rs_reg, rt_reg, rs_val, rt_val;
    logic              rs_ok, rt_ok, wb_ok, err_set;
    logic              hazard_stall, issue;
    logic              err_q;
    idex_t             ex_q;

    assign rs_ok = int'(bus.rs_sel) < REG_CNT;
    assign rt_ok = int'(bus.rt_sel) < REG_CNT;
    assign wb_ok = int'(bus.wb_sel) < REG_CNT;

    // Array read; an out-of-range select falls through to 0.
    always_comb begin
        rs_reg = '0;
        rt_reg = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            if (int'(bus.rs_sel) == i) rs_reg = regs[i];
            if (int'(bus.rt_sel) == i) rt_reg = regs[i];
        end
    end

    // Same-cycle writeback wins over the stored value.
    assign rs_val = (rs_ok && bus.wb_write && bus.wb_sel == bus.rs_sel) ? bus.wb_data : rs_reg;
    assign rt_val = (rt_ok && bus.wb_write && bus.wb_sel == bus.rt_sel) ? bus.wb_data : rt_reg;

    // Writeback into the array; out-of-range selects write nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (bus.wb_write && wb_ok) begin
            for (int i = 0; i < REG_CNT; i++)
                if (int'(bus.wb_sel) == i) regs[i] <= bus.wb_data;
        end
    end

    assign err_set = (bus.wb_write && !wb_ok) ||
                     (bus.id_valid && bus.rs_used && !rs_ok) ||
                     (bus.id_valid && bus.rt_used && !rt_ok);

    // Sticky illegal-access flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    id_scoreboard #(
        .REG_CNT (REG_CNT),
        .ADDR_W  (ADDR_W),
        .PEND_W  (PEND_W)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (bus.id_valid),
        .rs_sel       (bus.rs_sel),
        .rs_used      (bus.rs_used),
        .rt_sel       (bus.rt_sel),
        .rt_used      (bus.rt_used),
        .rd_sel       (bus.rd_sel),
        .rd_wr        (bus.rd_wr),
        .ex_stall     (bus.ex_stall),
        .flush        (bus.flush),
        .wb_write     (bus.wb_write),
        .wb_sel       (bus.wb_sel),
        .hazard_stall (hazard_stall),
        .issue        (issue)
    );

    // ID/EX register: flush, then execute hold, then bubble, then issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q.valid <= 1'b0;
        end else if (bus.ex_stall) begin
            ex_q <= ex_q;
        end else if (issue) begin
            ex_q <= '{valid: 1'b1, rs_data: rs_val, rt_data: rt_val,
                      rd_sel: bus.rd_sel, rd_wr: bus.rd_wr};
        end else begin
            ex_q.valid <= 1'b0;
            ex_q.rd_wr <= 1'b0;
        end
    end

    assign bus.hazard_stall = hazard_stall;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_rs_data   = ex_q.rs_data;
    assign bus.ex_rt_data   = ex_q.rt_data;
    assign bus.ex_rd_sel    = ex_q.rd_sel;
    assign bus.ex_rd_wr     = ex_q.rd_wr;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_id_scoreboard_rf.sv
// Directed and random checks of id_scoreboard_rf against a behavioural model.
module tb_id_scoreboard_rf;
    import id_scoreboard_rf_pkg::*;

    localparam int DW = 16;
    localparam int RC = 6;
    localparam int AW = 3;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_scoreboard_rf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    id_scoreboard_rf #(.DATA_W(DW), .REG_CNT(RC), .ADDR_W(AW), .PEND_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model state
    logic [DW-1:0] m_reg [RC];
    int            m_pend [RC];
    logic          m_err, m_ex_valid, m_ex_rd_wr;
    logic [DW-1:0] m_rs, m_rt;
    logic [AW-1:0] m_rd;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RC; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 0;
        end
        m_err = 1'b0; m_ex_valid = 1'b0; m_ex_rd_wr = 1'b0;
        m_rs = '0; m_rt = '0; m_rd = '0;
    endtask

    task automatic set_id(input logic v, input int rs, input logic rsu,
                          input int rt, input logic rtu, input int rd, input logic rdw);
        bus.id_valid = v;
        bus.rs_sel = AW'(rs); bus.rs_used = rsu;
        bus.rt_sel = AW'(rt); bus.rt_used = rtu;
        bus.rd_sel = AW'(rd); bus.rd_wr = rdw;
    endtask

    task automatic set_wb(input logic w, input int sel, input logic [DW-1:0] data);
        bus.wb_write = w; bus.wb_sel = AW'(sel); bus.wb_data = data;
    endtask

    task automatic idle();
        set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
        set_wb(1'b0, 0, '0);
        bus.ex_stall = 1'b0;
        bus.flush = 1'b0;
    endtask

    // A register is readable when nothing is outstanding, or when the only
    // outstanding write is arriving on writeback right now.
    function automatic bit m_ready(input int r);
        if (r >= RC) return 1'b1;
        return m_pend[r] == 0 ||
               (m_pend[r] == 1 && bus.wb_write && int'(bus.wb_sel) == r);
    endfunction

    function automatic bit m_stall();
        int rs = int'(bus.rs_sel), rt = int'(bus.rt_sel), rd = int'(bus.rd_sel);
        bit full = bus.rd_wr && rd < RC && m_pend[rd] == PEND_MAX;
        return bus.id_valid && !bus.flush &&
               ((bus.rs_used && !m_ready(rs)) || (bus.rt_used && !m_ready(rt)) || full);
    endfunction

    function automatic logic [DW-1:0] m_read(input int s);
        if (s >= RC) return '0;
        if (bus.wb_write && int'(bus.wb_sel) == s) return bus.wb_data;
        return m_reg[s];
    endfunction

    // One clock: check the combinational stall, advance the model, check ex_*.
    task automatic cycle();
        bit st, iss;
        int wb, rd, old_wb_pend;
        logic [DW-1:0] rsv, rtv;
        #1;
        st = m_stall();
        chk("hazard_stall", 32'(bus.hazard_stall), 32'(st));
        rsv = m_read(int'(bus.rs_sel));
        rtv = m_read(int'(bus.rt_sel));
        iss = bus.id_valid && !st && !bus.ex_stall && !bus.flush;
        wb = int'(bus.wb_sel);
        rd = int'(bus.rd_sel);
        if ((bus.wb_write && wb >= RC) ||
            (bus.id_valid && bus.rs_used && int'(bus.rs_sel) >= RC) ||
            (bus.id_valid && bus.rt_used && int'(bus.rt_sel) >= RC)) m_err = 1'b1;
        if (bus.flush) m_ex_valid = 1'b0;
        else if (bus.ex_stall) ;
        else if (st || !bus.id_valid) begin m_ex_valid = 1'b0; m_ex_rd_wr = 1'b0; end
        else begin
            m_ex_valid = 1'b1; m_rs = rsv; m_rt = rtv; m_rd = bus.rd_sel; m_ex_rd_wr = bus.rd_wr;
        end
        if (bus.flush) begin
            for (int i = 0; i < RC; i++) m_pend[i] = 0;
        end else begin
            old_wb_pend = (wb < RC) ? m_pend[wb] : 0;
            if (iss && bus.rd_wr && rd < RC) m_pend[rd]++;
            if (bus.wb_write && wb < RC && old_wb_pend > 0) m_pend[wb]--;
        end
        if (bus.wb_write && wb < RC) m_reg[wb] = bus.wb_data;
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_ex_valid));
        chk("ex_rd_wr", 32'(bus.ex_rd_wr), 32'(m_ex_rd_wr));
        chk("err", 32'(bus.err), 32'(m_err));
        if (m_ex_valid) begin
            chk("ex_rs_data", 32'(bus.ex_rs_data), 32'(m_rs));
            chk("ex_rt_data", 32'(bus.ex_rt_data), 32'(m_rt));
            chk("ex_rd_sel", 32'(bus.ex_rd_sel), 32'(m_rd));
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_ex_rs", 32'(bus.ex_rs_data), 32'd0);
        chk("rst_ex_rd_wr", 32'(bus.ex_rd_wr), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_stall", 32'(bus.hazard_stall), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Writeback then read through the array
        set_wb(1'b1, 3, 16'hBEEF); cycle();
        set_wb(1'b0, 0, '0); set_id(1'b1, 3, 1'b1, 0, 1'b0, 0, 1'b0); cycle();
        chk("wb_read_valid", 32'(bus.ex_valid), 32'd1);
        chk("wb_read_data", 32'(bus.ex_rs_data), 32'hBEEF);

        // Same-cycle bypass
        set_wb(1'b1, 5, 16'h1234); set_id(1'b1, 0, 1'b0, 5, 1'b1, 0, 1'b0);
        #1 chk("bypass_nostall", 32'(bus.hazard_stall), 32'd0);
        cycle();
        chk("bypass_data", 32'(bus.ex_rt_data), 32'h1234);

        // RAW hazard on r2
        set_wb(1'b0, 0, '0); set_id(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1); cycle();
        set_id(1'b1, 2, 1'b1, 0, 1'b0, 0, 1'b0);
        #1 chk("raw_stall", 32'(bus.hazard_stall), 32'd1);
        cycle();
        chk("raw_bubble", 32'(bus.ex_valid), 32'd0);
        cycle();
        set_wb(1'b1, 2, 16'hA5A5);
        #1 chk("raw_release", 32'(bus.hazard_stall), 32'd0);
        cycle();
        chk("raw_data", 32'(bus.ex_rs_data), 32'hA5A5);

        // Counter saturation on r1
        set_wb(1'b0, 0, '0); set_id(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1);
        for (int i = 0; i < PEND_MAX; i++) cycle();
        #1 chk("sat_stall", 32'(bus.hazard_stall), 32'd1);
        cycle();
        set_wb(1'b1, 1, 16'h1111); cycle();
        set_wb(1'b0, 0, '0);
        #1 chk("sat_release", 32'(bus.hazard_stall), 32'd0);
        cycle();

        // Flush with two writes pending on r4
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1); cycle(); cycle();
        chk("pre_flush_valid", 32'(bus.ex_valid), 32'd1);
        idle(); bus.flush = 1'b1; cycle();
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);
        bus.flush = 1'b0; set_id(1'b1, 4, 1'b1, 0, 1'b0, 0, 1'b0);
        #1 chk("flush_nostall", 32'(bus.hazard_stall), 32'd0);
        cycle();
        idle(); set_wb(1'b1, 4, 16'h4444); cycle();
        // Counter must still be 0: exactly PEND_MAX issues fit before the stall
        set_wb(1'b0, 0, '0); set_id(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1);
        for (int i = 0; i < PEND_MAX; i++) cycle();
        #1 chk("late_wb_pend0", 32'(bus.hazard_stall), 32'd1);
        idle(); bus.flush = 1'b1; cycle(); bus.flush = 1'b0;

        // Out-of-range writeback
        set_wb(1'b1, 7, 16'hDEAD);
        #1 chk("err_before", 32'(bus.err), 32'd0);
        cycle();
        chk("err_set", 32'(bus.err), 32'd1);
        set_wb(1'b0, 0, '0);
        for (int r = 0; r < RC; r++) begin
            set_id(1'b1, r, 1'b1, r, 1'b1, 0, 1'b0); cycle();
        end
        idle(); cycle(); cycle();
        chk("err_sticky", 32'(bus.err), 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 6), 1'($urandom),
                   $urandom_range(0, 6), 1'($urandom), $urandom_range(0, 6), 1'($urandom));
            set_wb(1'($urandom), $urandom_range(0, 6), DW'($urandom));
            bus.ex_stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            cycle();
        end

        // Reset in the middle of a stall
        idle(); bus.flush = 1'b1; cycle(); bus.flush = 1'b0;
        set_id(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1); cycle();
        set_id(1'b1, 2, 1'b1, 0, 1'b0, 0, 1'b0);
        #1 chk("pre_rst_stall", 32'(bus.hazard_stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stall", 32'(bus.hazard_stall), 32'd0);
        chk("midrst_valid", 32'(bus.ex_valid), 32'd0);
        chk("midrst_rs", 32'(bus.ex_rs_data), 32'd0);
        chk("midrst_rt", 32'(bus.ex_rt_data), 32'd0);
        chk("midrst_rd", 32'(bus.ex_rd_sel), 32'd0);
        chk("midrst_rd_wr", 32'(bus.ex_rd_wr), 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        model_reset();
        idle();
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        set_id(1'b1, 2, 1'b1, 3, 1'b1, 0, 1'b0); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_scoreboard_rf.md
Name: id_scoreboard_rf

Overview:
- Parametrised decode-stage register file and next-generation successor of the bypassing register file in the decode stage.
- Adds a per-register pending-write scoreboard that detects RAW hazards on in-flight writes and raises a stall.
- Adds a registered ID/EX operand stage that inserts a bubble on stall.
- Sits between the instruction fetch/decode control logic and execute. Writeback drives its write port.

Parameters:
- DATA_W, 16: register data width.
- REG_CNT, 8: number of architectural registers.
- ADDR_W, 3: register-select width; REG_CNT <= 2**ADDR_W.
- PEND_W, 2: width of each pending-write counter; max in-flight writes per register = 2**PEND_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- rs_sel  in  ADDR_W  source 1 register
- rs_used  in  1  instruction reads rs
- rt_sel  in  ADDR_W  source 2 register
- rt_used  in  1  instruction reads rt
- rd_sel  in  ADDR_W  destination register
- rd_wr  in  1  instruction writes rd
- ex_stall  in  1  execute cannot accept; hold ID/EX
- flush  in  1  squash decode and ID/EX, clear scoreboard
- wb_write  in  1  writeback enable
- wb_sel  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback data
- hazard_stall  out  1  decode must hold (combinational)
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_rs_data  out  DATA_W  registered operand 1
- ex_rt_data  out  DATA_W  registered operand 2
- ex_rd_sel  out  ADDR_W  registered destination
- ex_rd_wr  out  1  registered write flag
- err  out  1  sticky illegal-access flag

Behaviour:
- Single clock clk. rst is asynchronous, active-high.
- Reset: all registers, all pending counters, ex_valid, ex_rs_data, ex_rt_data, ex_rd_sel, ex_rd_wr and err are 0. hazard_stall is 0 after reset because all counters are 0.
- Write port:
  - On a clk edge with wb_write=1 and wb_sel<REG_CNT, reg[wb_sel] <= wb_data.
  - Out-of-range wb_sel performs no write and sets err.
- Read with bypass:
  - rs_val = (wb_write && wb_sel==rs_sel) ? wb_data : reg[rs_sel]. rt_val is formed the same way.
  - A read of an out-of-range select returns 0 and sets err, only when id_valid and the corresponding *_used is 1.
- Scoreboard: one counter pend[r] of PEND_W bits per register.
  - ready(r) = pend[r]==0, or (pend[r]==1 && wb_write && wb_sel==r). A write landing this cycle satisfies the read via bypass.
  - hazard_stall = id_valid && !flush && ((rs_used && !ready(rs_sel)) || (rt_used && !ready(rt_sel)) || (rd_wr && pend[rd_sel]==max)). The last term blocks counter overflow.
  - issue = id_valid && !hazard_stall && !ex_stall && !flush.
  - Per register r:
    - inc = issue && rd_wr && rd_sel==r.
    - dec = wb_write && wb_sel==r && pend[r]!=0.
    - inc and dec together: no change. Otherwise increment or decrement by 1.
    - Decrement at 0 is ignored (no error); this covers writebacks of instructions squashed by flush.
  - flush: all pend <= 0, overriding inc/dec in the same cycle.
- ID/EX stage, updated on every edge, with priority in this order:
  - flush: ex_valid <= 0.
  - ex_stall: hold all ex_* outputs.
  - hazard_stall or !id_valid: ex_valid <= 0 (bubble), ex_rd_wr <= 0, data fields may hold.
  - issue: ex_valid <= 1, ex_rs_data <= rs_val, ex_rt_data <= rt_val, ex_rd_sel <= rd_sel, ex_rd_wr <= rd_wr.
- Latency: operand to ex_* outputs is 1 cycle. hazard_stall is same-cycle.
- err: set on any illegal access; cleared only by rst.
- Reset mid-operation: all state is cleared asynchronously; the pending scoreboard is lost by design.

Decomposition:
- Shared package holds: the DATA_W, REG_CNT, ADDR_W and PEND_W defaults; a pend_max constant (2**PEND_W-1); and the packed ID/EX record type (valid, rs_data, rt_data, rd_sel, rd_wr).
- One natural sub-module: id_scoreboard, holding the counter array, ready/hazard logic and flush handling.
- The register array and bypass stay in the top module.

Test Plan:
- Reset, then a writeback drives wb_write=1, wb_sel=3, wb_data=16'hBEEF.
  - Next cycle an instruction with rs_sel=3 issues.
  - Required: ex_valid=1 and ex_rs_data=16'hBEEF one cycle later.
- Same-cycle bypass: wb_write to r5 with 16'h1234 while rt_sel=5.
  - Required: ex_rt_data=16'h1234 on the next edge; no stall.
- RAW hazard:
  - Issue rd_sel=2, rd_wr=1. Next instruction uses rs_sel=2.
  - Required: hazard_stall=1 and ex_valid=0 bubbles until wb_write to r2.
  - In the writeback cycle hazard_stall=0 and ex_rs_data equals the written value.
- Counter saturation, PEND_W=2: issue three writes to r1 with no writeback.
  - Required: a fourth rd_sel=1 instruction raises hazard_stall. One wb to r1 releases it.
- flush with pend[4]=2 and ex_valid=1.
  - Required: next cycle ex_valid=0 and a rs_sel=4 read proceeds without stall.
  - A later wb to r4 is accepted and pend stays 0.
- REG_CNT=6 with wb_sel=7.
  - Required: no register changes, err=1, err stays 1 until rst.
  - Assert rst mid-stall: all outputs return to 0 immediately.
